// File: rtl/unidade_emissao_if.sv
// Issue-stage bus: instruction-queue handshake, reservation-station free flags,
// dispatch fields and status outputs of unidade_emissao.
// master = issue unit side, slave = queue / reservation-station / observer side.
interface unidade_emissao_if;
    logic        instInEn;
    logic [15:0] instIn;
    logic        disponivel;
    logic        rsArithLivre;
    logic        rsMemLivre;
    logic        issueValid;
    logic        issueMem;
    logic [3:0]  issueOp;
    logic [3:0]  issueRd;
    logic [3:0]  issueRs;
    logic [3:0]  issueRt;
    logic        illegalOp;
    logic        overflowErr;
    logic [15:0] stallCount;

    modport master (
        input  instInEn, instIn, rsArithLivre, rsMemLivre,
        output disponivel, issueValid, issueMem, issueOp, issueRd, issueRs, issueRt,
        output illegalOp, overflowErr, stallCount
    );

    modport slave (
        output instInEn, instIn, rsArithLivre, rsMemLivre,
        input  disponivel, issueValid, issueMem, issueOp, issueRd, issueRs, issueRt,
        input  illegalOp, overflowErr, stallCount
    );
endinterface

// File: rtl/unidade_emissao.sv
// Issue stage: pulls instructions from the instruction queue into a small in-order
// buffer and dispatches the head to the arithmetic or load/store reservation station.
// Optional feature macro: STALL_CNT_EN enables the saturating stall-cycle counter;
// without it stallCount is tied to zero.
module unidade_emissao #(
    parameter int unsigned DEPTH = 2
) (
    input logic               clock,
    input logic               reset,
    unidade_emissao_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [15:0]   buffer [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [15:0] head_word;
    logic [3:0]  head_op;
    logic        head_valid;
    logic        head_illegal;
    logic        head_is_mem;
    logic        head_ready;
    logic        pop;
    logic        dispatch;
    logic        push;
    logic        write_ok;
    logic        drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Decode the head entry and decide push/pop for this edge
    always_comb begin
        head_word    = buffer[head];
        head_op      = head_word[15:12];
        head_valid   = (count != '0);
        head_illegal = (head_op[3:2] != 2'b00);
        head_is_mem  = head_op[1];
        head_ready   = head_is_mem ? bus.rsMemLivre : bus.rsArithLivre;
        pop          = head_valid && (head_illegal || head_ready);
        dispatch     = pop && !head_illegal;
        push         = bus.instInEn;
        // At full a push is still legal when the head leaves on the same edge
        write_ok     = push && ((count != CW'(DEPTH)) || pop);
        drop         = push && !write_ok;
    end

    // Only registered count feeds the request, leaving room for the word in flight
    assign bus.disponivel = !reset && (count <= CW'(DEPTH - 2));

    // Buffer storage; reset only needs to clear the occupancy, not the data
    always_ff @(posedge clock) begin
        if (write_ok) begin
            buffer[tail] <= bus.instIn;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (write_ok) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (write_ok && !pop) begin
                count <= count + 1'b1;
            end else if (!write_ok && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Registered dispatch outputs; fields hold their last dispatched value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.issueValid <= 1'b0;
            bus.illegalOp  <= 1'b0;
            bus.issueMem   <= 1'b0;
            bus.issueOp    <= 4'h0;
            bus.issueRd    <= 4'h0;
            bus.issueRs    <= 4'h0;
            bus.issueRt    <= 4'h0;
        end else begin
            bus.issueValid <= dispatch;
            bus.illegalOp  <= pop && head_illegal;
            if (dispatch) begin
                bus.issueMem <= head_is_mem;
                bus.issueOp  <= head_op;
                bus.issueRd  <= head_word[11:8];
                bus.issueRs  <= head_word[7:4];
                bus.issueRt  <= head_word[3:0];
            end
        end
    end

    // Sticky overflow flag: a word arrived with nowhere to go
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.overflowErr <= 1'b0;
        end else if (drop) begin
            bus.overflowErr <= 1'b1;
        end
    end

`ifdef STALL_CNT_EN
    logic        stall;
    logic [15:0] stall_cnt;

    assign stall = head_valid && !head_illegal && !head_ready;

    // Saturating count of edges where a legal head waits for its station
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'h0000;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

    assign bus.stallCount = stall_cnt;
`else
    assign bus.stallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_unidade_emissao.sv
// Directed bench for unidade_emissao (DEPTH=3). Inputs change and outputs are
// checked on the falling edge; the DUT acts on the rising edge.
module tb_unidade_emissao;

    localparam int unsigned DEPTH = 3;
`ifdef STALL_CNT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    unidade_emissao_if bus ();

    unidade_emissao #(
        .DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic en, input logic [15:0] word);
        bus.instInEn = en;
        bus.instIn   = word;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected dispatch of instruction word w
    task automatic chk_issue(input string tag, input logic mem, input logic [15:0] w);
        check({tag, "_valid"}, 16'(bus.issueValid), 16'h1);
        check({tag, "_mem"}, 16'(bus.issueMem), 16'(mem));
        check({tag, "_op"}, 16'(bus.issueOp), 16'(w[15:12]));
        check({tag, "_rd"}, 16'(bus.issueRd), 16'(w[11:8]));
        check({tag, "_rs"}, 16'(bus.issueRs), 16'(w[7:4]));
        check({tag, "_rt"}, 16'(bus.issueRt), 16'(w[3:0]));
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b1;
        bus.instInEn     = 1'b0;
        bus.instIn       = 16'h0000;
        bus.rsArithLivre = 1'b1;
        bus.rsMemLivre   = 1'b1;
        repeat (2) @(negedge clock);

        // Reset state
        check("rst_disp", 16'(bus.disponivel), 16'h0);
        check("rst_valid", 16'(bus.issueValid), 16'h0);
        check("rst_illegal", 16'(bus.illegalOp), 16'h0);
        check("rst_ovf", 16'(bus.overflowErr), 16'h0);
        check("rst_stall", bus.stallCount, 16'h0);
        check("rst_fields", {3'b0, bus.issueMem, bus.issueOp, bus.issueRd, bus.issueRs},
              16'h0);
        check("rst_rt", 16'(bus.issueRt), 16'h0);

        // 1: single ADD, two-edge latency
        reset = 1'b0;
        #1 check("t1_disp", 16'(bus.disponivel), 16'h1);
        tick();
        drive(1'b1, 16'h0312);
        tick();
        drive(1'b0, 16'h0000);
        check("t1_early", 16'(bus.issueValid), 16'h0);
        tick();
        chk_issue("t1", 1'b0, 16'h0312);
        tick();
        check("t1_pulse_end", 16'(bus.issueValid), 16'h0);
        check("t1_hold_rd", 16'(bus.issueRd), 16'h3);

        // 2: back-to-back stream, request stays high
        drive(1'b1, 16'h0312);
        tick();
        check("t2_disp0", 16'(bus.disponivel), 16'h1);
        check("t2_v0", 16'(bus.issueValid), 16'h0);
        drive(1'b1, 16'h1531);
        tick();
        chk_issue("t2_a", 1'b0, 16'h0312);
        check("t2_disp1", 16'(bus.disponivel), 16'h1);
        drive(1'b1, 16'h2306);
        tick();
        chk_issue("t2_b", 1'b0, 16'h1531);
        check("t2_disp2", 16'(bus.disponivel), 16'h1);
        drive(1'b1, 16'h3104);
        tick();
        chk_issue("t2_c", 1'b1, 16'h2306);
        check("t2_disp3", 16'(bus.disponivel), 16'h1);
        drive(1'b0, 16'h0000);
        tick();
        chk_issue("t2_d", 1'b1, 16'h3104);
        check("t2_ovf", 16'(bus.overflowErr), 16'h0);
        tick();
        check("t2_idle", 16'(bus.issueValid), 16'h0);

        // 3: arithmetic station busy, buffer fills, then drains in order
        bus.rsArithLivre = 1'b0;
        drive(1'b1, 16'h0123);
        tick();
        check("t3_disp_c1", 16'(bus.disponivel), 16'h1);
        drive(1'b1, 16'h0456);
        tick();
        check("t3_disp_c2", 16'(bus.disponivel), 16'h0);
        drive(1'b1, 16'h0789);  // in flight, must be accepted
        tick();
        drive(1'b0, 16'h0000);
        check("t3_ovf_full", 16'(bus.overflowErr), 16'h0);
        check("t3_disp_full", 16'(bus.disponivel), 16'h0);
        tick();
        check("t3_blocked", 16'(bus.issueValid), 16'h0);
        bus.rsArithLivre = 1'b1;
        tick();
        chk_issue("t3_a", 1'b0, 16'h0123);
        check("t3_disp_d2", 16'(bus.disponivel), 16'h0);
        tick();
        chk_issue("t3_b", 1'b0, 16'h0456);
        check("t3_disp_d1", 16'(bus.disponivel), 16'h1);
        tick();
        chk_issue("t3_c", 1'b0, 16'h0789);
        tick();
        check("t3_idle", 16'(bus.issueValid), 16'h0);

        // 4: blocked ADD head holds back a ready LD
        bus.rsArithLivre = 1'b0;
        drive(1'b1, 16'h0abc);
        tick();
        drive(1'b1, 16'h3def);
        tick();
        drive(1'b0, 16'h0000);
        check("t4_hold0", 16'(bus.issueValid), 16'h0);
        tick();
        check("t4_hold1", 16'(bus.issueValid), 16'h0);
        tick();
        check("t4_hold2", 16'(bus.issueValid), 16'h0);
        bus.rsArithLivre = 1'b1;
        tick();
        chk_issue("t4_add", 1'b0, 16'h0abc);
        tick();
        chk_issue("t4_ld", 1'b1, 16'h3def);
        tick();
        check("t4_idle", 16'(bus.issueValid), 16'h0);

        // 5: illegal opcode between two ADDs
        drive(1'b1, 16'h0111);
        tick();
        drive(1'b1, 16'h4123);
        tick();
        chk_issue("t5_a", 1'b0, 16'h0111);
        check("t5_ill0", 16'(bus.illegalOp), 16'h0);
        drive(1'b1, 16'h0222);
        tick();
        drive(1'b0, 16'h0000);
        check("t5_ill_pulse", 16'(bus.illegalOp), 16'h1);
        check("t5_ill_novalid", 16'(bus.issueValid), 16'h0);
        check("t5_ill_hold_rd", 16'(bus.issueRd), 16'h1);
        tick();
        chk_issue("t5_b", 1'b0, 16'h0222);
        check("t5_ill_end", 16'(bus.illegalOp), 16'h0);
        tick();
        check("t5_idle", 16'(bus.issueValid), 16'h0);

        // 5b: forced push at full with no pop
        bus.rsArithLivre = 1'b0;
        drive(1'b1, 16'h0301);
        tick();
        drive(1'b1, 16'h0302);
        tick();
        drive(1'b1, 16'h0303);
        tick();
        check("t5_ovf_pre", 16'(bus.overflowErr), 16'h0);
        drive(1'b1, 16'h0304);
        tick();
        drive(1'b0, 16'h0000);
        check("t5_ovf_set", 16'(bus.overflowErr), 16'h1);
        bus.rsArithLivre = 1'b1;
        tick();
        chk_issue("t5_d1", 1'b0, 16'h0301);
        tick();
        chk_issue("t5_d2", 1'b0, 16'h0302);
        tick();
        chk_issue("t5_d3", 1'b0, 16'h0303);
        tick();
        check("t5_dropped", 16'(bus.issueValid), 16'h0);
        check("t5_ovf_sticky", 16'(bus.overflowErr), 16'h1);

        // 6: stall counter, then reset mid-stall
        reset = 1'b1;
        #1 check("t6_ovf_clr", 16'(bus.overflowErr), 16'h0);
        check("t6_stall_clr", bus.stallCount, 16'h0);
        tick();
        reset = 1'b0;
        bus.rsArithLivre = 1'b0;
        drive(1'b1, 16'h0555);
        tick();
        drive(1'b0, 16'h0000);
        repeat (5) tick();
        check("t6_stall5", bus.stallCount, STALL_ON ? 16'd5 : 16'd0);
        reset = 1'b1;
        #1 check("t6_rst_stall", bus.stallCount, 16'h0);
        check("t6_rst_disp", 16'(bus.disponivel), 16'h0);
        check("t6_rst_valid", 16'(bus.issueValid), 16'h0);
        tick();
        check("t6_rst_disp_edge", 16'(bus.disponivel), 16'h0);

        // Word presented on the first edge after release is accepted; old ADD is gone
        reset = 1'b0;
        bus.rsArithLivre = 1'b1;
        drive(1'b1, 16'h1234);
        tick();
        drive(1'b0, 16'h0000);
        check("t6_no_stale", 16'(bus.issueValid), 16'h0);
        tick();
        chk_issue("t6_first", 1'b0, 16'h1234);
        check("t6_stall_end", bus.stallCount, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
